// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave Wishbone classic arbiter with
// round-robin grant. The owner keeps the bus for its whole cyc. When the
// owner releases and the other master is waiting, the bus passes straight
// across with no idle cycle.
// Optional ack timeout: define WB_ARB_TIMEOUT_EN to build it.
module wb_arbiter2 #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [1:0] grant_q;
  logic       timeoutHit;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // The ack wins over a timeout landing in the same cycle.
  assign timeoutHit = s_stb_o & ~s_ack_i & (cnt_q == CW'(TIMEOUT - 1));

  // Count consecutive unacked strobe cycles; restart on ack, stb low or owner change.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || !s_stb_o || s_ack_i) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Timeout counter register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  // Counter compiled out: no error can ever fire. TIMEOUT is referenced
  // only so that both builds share one parameter list.
  assign timeoutHit = 1'b0 & (TIMEOUT != 0);
`endif

  // Round-robin arbitration and the owner-release / timeout-abort transitions.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_q ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_d = OWN0;
        end else if (m1_cyc_i) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (timeoutHit) begin
          state_d = IDLE;
          last_d  = 1'b0;
        end else if (!m0_cyc_i) begin
          last_d  = 1'b0;
          state_d = m1_cyc_i ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (timeoutHit) begin
          state_d = IDLE;
          last_d  = 1'b1;
        end else if (!m1_cyc_i) begin
          last_d  = 1'b1;
          state_d = m0_cyc_i ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, last-owner and one-hot grant registers; last resets to 1 so m0 wins the first tie.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= {state_d == OWN1, state_d == OWN0};
    end
  end

  assign grant_o = grant_q;

  // Route the owner's request to the slave and return ack/data/err only to the owner.
  always_comb begin
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      OWN0: begin
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_err_o = timeoutHit;
      end
      OWN1: begin
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_err_o = timeoutHit;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed scenarios plus a randomized run of wb_arbiter2,
// compared every cycle against a bus-ownership reference model.
module tb_wb_arbiter2;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic          wb_clk_i, wb_rst_i;
  logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]    m0_sel_i, m1_sel_i;
  logic [31:0]   m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [31:0]   m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;
  logic [3:0]    s_sel_o;
  logic [31:0]   s_adr_o, s_dat_o, s_dat_i;
  logic [1:0]    grant_o;

  int vecCount = 0;
  int errCount = 0;

  // Reference model: who owns the bus (0 none, 1 master 0, 2 master 1),
  // which master released last, and how long the current strobe has waited.
  int ownM, lastM, waitM;
  logic        eCyc, eStb, eWe, eAck0, eAck1, eErr0, eErr1, eHit;
  logic [3:0]  eSel;
  logic [31:0] eAdr, eDat, eRd0, eRd1;
  logic [1:0]  eGrant;

  logic [1:0] gq[$];
  logic       n0, n1;

  wb_arbiter2 #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  // Free-running 100 MHz clock.
  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected combinational outputs for the current owner and inputs.
  task automatic modelOutputs();
    eCyc = 0; eStb = 0; eWe = 0; eSel = '0; eAdr = '0; eDat = '0;
    eAck0 = 0; eAck1 = 0; eRd0 = '0; eRd1 = '0; eErr0 = 0; eErr1 = 0; eGrant = 2'b00;
    if (ownM == 1) begin
      eCyc = m0_cyc_i; eStb = m0_stb_i; eWe = m0_we_i; eSel = m0_sel_i;
      eAdr = m0_adr_i; eDat = m0_dat_i; eRd0 = s_dat_i; eAck0 = s_ack_i & m0_stb_i;
      eGrant = 2'b01;
    end else if (ownM == 2) begin
      eCyc = m1_cyc_i; eStb = m1_stb_i; eWe = m1_we_i; eSel = m1_sel_i;
      eAdr = m1_adr_i; eDat = m1_dat_i; eRd1 = s_dat_i; eAck1 = s_ack_i & m1_stb_i;
      eGrant = 2'b10;
    end
    eHit = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    eHit = (ownM != 0) && eStb && !s_ack_i && (waitM == TIMEOUT - 1);
`endif
    eErr0 = eHit && (ownM == 1);
    eErr1 = eHit && (ownM == 2);
  endtask

  // Advance the model by one clock edge.
  task automatic modelUpdate();
    int prev;
    modelOutputs();
    prev = ownM;
    if (wb_rst_i) begin
      ownM = 0; lastM = 1; waitM = 0;
    end else begin
      if (eHit) begin
        lastM = ownM - 1;
        ownM  = 0;
      end else if (ownM == 0) begin
        if (m0_cyc_i && m1_cyc_i) ownM = (lastM == 1) ? 1 : 2;
        else if (m0_cyc_i) ownM = 1;
        else if (m1_cyc_i) ownM = 2;
      end else if (ownM == 1 && !m0_cyc_i) begin
        lastM = 0;
        ownM  = m1_cyc_i ? 2 : 0;
      end else if (ownM == 2 && !m1_cyc_i) begin
        lastM = 1;
        ownM  = m0_cyc_i ? 1 : 0;
      end
      if (ownM != prev || !eStb || s_ack_i) waitM = 0;
      else waitM = waitM + 1;
    end
  endtask

  task automatic checkAll();
    modelOutputs();
    checkOutput("grant", grant_o, eGrant);
    checkOutput("s_cyc", s_cyc_o, eCyc);
    checkOutput("s_stb", s_stb_o, eStb);
    checkOutput("s_we", s_we_o, eWe);
    checkOutput("s_sel", s_sel_o, eSel);
    checkOutput("s_adr", s_adr_o, eAdr);
    checkOutput("s_dat", s_dat_o, eDat);
    checkOutput("m0_ack", m0_ack_o, eAck0);
    checkOutput("m1_ack", m1_ack_o, eAck1);
    checkOutput("m0_dat", m0_dat_o, eRd0);
    checkOutput("m1_dat", m1_dat_o, eRd1);
    checkOutput("m0_err", m0_err_o, eErr0);
    checkOutput("m1_err", m1_err_o, eErr1);
  endtask

  // One cycle: check at the falling edge, step the model at the rising edge.
  task automatic tick();
    @(negedge wb_clk_i);
    checkAll();
    @(posedge wb_clk_i);
    modelUpdate();
    #1;
  endtask

  task automatic idleInputs();
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 4'hf; m0_adr_i = '0; m0_dat_i = '0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 4'hf; m1_adr_i = '0; m1_dat_i = '0;
    s_ack_i = 0; s_dat_i = '0;
  endtask

  task automatic resetDut();
    idleInputs();
    wb_rst_i = 1'b1;
    repeat (2) begin
      @(posedge wb_clk_i);
      modelUpdate();
      #1;
    end
    wb_rst_i = 1'b0;
  endtask

  // Random per-cycle master/slave activity with occasional reset.
  task automatic applyStimulus();
    if ($urandom_range(0, 3) == 0) m0_cyc_i = ~m0_cyc_i;
    if ($urandom_range(0, 3) == 0) m1_cyc_i = ~m1_cyc_i;
    m0_stb_i = m0_cyc_i & 1'($urandom_range(0, 1));
    m1_stb_i = m1_cyc_i & 1'($urandom_range(0, 1));
    m0_we_i  = 1'($urandom_range(0, 1));
    m1_we_i  = 1'($urandom_range(0, 1));
    m0_sel_i = 4'($urandom());
    m1_sel_i = 4'($urandom());
    m0_adr_i = $urandom(); m0_dat_i = $urandom();
    m1_adr_i = $urandom(); m1_dat_i = $urandom();
    s_ack_i  = 1'($urandom_range(0, 1));
    s_dat_i  = $urandom();
    wb_rst_i = ($urandom_range(0, 63) == 0);
  endtask

  initial begin
    ownM = 0; lastM = 1; waitM = 0;
    resetDut();

    // Reset state, then an m0 read.
    #1;
    checkOutput("rst_grant", grant_o, 2'b00);
    checkOutput("rst_s_cyc", s_cyc_o, 1'b0);
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'haabbccdd;
    tick();
    #1;
    checkOutput("t1_grant", grant_o, 2'b01);
    checkOutput("t1_adr", s_adr_o, 32'haabbccdd);
    s_ack_i = 1; s_dat_i = 32'h33445566;
    #1;
    checkOutput("t1_rdat", m0_dat_o, 32'h33445566);
    checkOutput("t1_ack0", m0_ack_o, 1'b1);
    checkOutput("t1_ack1", m1_ack_o, 1'b0);
    tick();
    idleInputs();
    tick(); tick();

    // Simultaneous request after reset, then direct handover to m1.
    resetDut();
    m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h00000010;
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_adr_i = 32'haaaa5555; m1_dat_i = 32'h01010202;
    tick();
    #1;
    checkOutput("t2_grant0", grant_o, 2'b01);
    s_ack_i = 1;
    tick();
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    tick();
    #1;
    checkOutput("t2_grant1", grant_o, 2'b10);
    checkOutput("t2_adr", s_adr_o, 32'haaaa5555);
    checkOutput("t2_dat", s_dat_o, 32'h01010202);
    checkOutput("t2_we", s_we_o, 1'b1);
    s_ack_i = 1;
    tick();
    idleInputs();
    tick(); tick();

    // Fairness: both masters keep requesting one word at a time.
    resetDut();
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; s_ack_i = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (m0_ack_o || m1_ack_o) gq.push_back(grant_o);
      n0 = !m0_ack_o;
      n1 = !m1_ack_o;
      tick();
      m0_cyc_i = n0; m0_stb_i = n0; m1_cyc_i = n1; m1_stb_i = n1;
    end
    checkOutput("t3_xfers", gq.size() >= 4, 1'b1);
    for (int k = 0; k < 4; k++)
      checkOutput($sformatf("t3_grant%0d", k), (k < gq.size()) ? gq[k] : 2'b00,
                  (k % 2 == 0) ? 2'b01 : 2'b10);
    idleInputs();
    tick(); tick();

    // Reset while m1 owns the bus mid-strobe.
    resetDut();
    m1_cyc_i = 1; m1_stb_i = 1;
    tick();
    #1;
    checkOutput("t4_own1", grant_o, 2'b10);
    wb_rst_i = 1;
    tick();
    s_ack_i = 1;
    #1;
    checkOutput("t4_s_cyc", s_cyc_o, 1'b0);
    checkOutput("t4_grant", grant_o, 2'b00);
    checkOutput("t4_ack1", m1_ack_o, 1'b0);
    wb_rst_i = 0; s_ack_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    tick();
    #1;
    checkOutput("t4_tie", grant_o, 2'b01);
    idleInputs();
    tick(); tick();

    // Stray slave acks: while idle and while the owner's stb is low.
    s_ack_i = 1;
    #1;
    checkOutput("t6_idle_ack0", m0_ack_o, 1'b0);
    checkOutput("t6_idle_ack1", m1_ack_o, 1'b0);
    m0_cyc_i = 1;
    tick();
    #1;
    checkOutput("t6_stblow_ack", m0_ack_o, 1'b0);
    checkOutput("t6_stblow_stb", s_stb_o, 1'b0);
    idleInputs();
    tick(); tick();

    // Slave never acks a strobe from m0.
    resetDut();
    m0_cyc_i = 1; m0_stb_i = 1;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    for (int k = 1; k <= TIMEOUT; k++) begin
      #1;
      checkOutput($sformatf("t5_err_c%0d", k), m0_err_o, k == TIMEOUT);
      tick();
    end
    #1;
    checkOutput("t5_s_cyc", s_cyc_o, 1'b0);
    checkOutput("t5_grant", grant_o, 2'b00);
    checkOutput("t5_err_after", m0_err_o, 1'b0);
`else
    for (int k = 1; k <= 30; k++) begin
      #1;
      checkOutput($sformatf("t5_err_c%0d", k), m0_err_o, 1'b0);
      tick();
    end
    #1;
    checkOutput("t5_held_cyc", s_cyc_o, 1'b1);
    checkOutput("t5_held_grant", grant_o, 2'b01);
`endif
    idleInputs();
    tick(); tick();

    // Randomized traffic against the model.
    resetDut();
    for (int i = 0; i < 800; i++) begin
      applyStimulus();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule

// File: doc/wb_arbiter2.md
Name: wb_arbiter2

Overview:
- Two-master, one-slave Wishbone classic arbiter with round-robin grant.
- Lets two wb_master instances (e.g. a CPU model and a DMA model) share one 32-bit slave bus.
- Slave-side request signals are muxed from the granted master; ack and read data are routed back only to the owner.
- Sits between the wb_master VIP instances and the slave/interconnect under test.

Parameters:
- AW, 32, address width.
- DW, 32, data width. Select width is DW/8.
- TIMEOUT, 16, cycles to wait for ack before aborting. Used only with WB_ARB_TIMEOUT_EN.

Ports:
- wb_clk_i  in  1  clock, all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  master 0 cycle, strobe and write enable.
- m0_sel_i  in  DW/8  master 0 byte select.
- m0_adr_i  in  AW  master 0 address.
- m0_dat_i  in  DW  master 0 write data.
- m0_dat_o  out  DW  read data to master 0.
- m0_ack_o  out  1  ack to master 0.
- m0_err_o  out  1  timeout error to master 0.
- m1_*  same set as m0_*, for master 1.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  slave cycle, strobe and write enable.
- s_sel_o  out  DW/8  slave byte select.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave ack.
- grant_o  out  2  one-hot current owner; 00 when idle.

Behaviour:
- One clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values:
  - State IDLE, grant_o = 00, last = 1 (so master 0 wins the first tie).
  - All s_* control outputs 0; mX_ack_o = 0 and mX_err_o = 0.
  - Timeout counter 0.
- Reset asserted mid-transfer drops s_cyc_o and s_stb_o on the next edge. No ack or err is generated for the aborted transfer.
- States: IDLE, OWN0, OWN1. grant_o is a registered decode of the state.
- IDLE:
  - Only m0_cyc_i high -> OWN0. Only m1_cyc_i high -> OWN1.
  - Both high -> grant the master not equal to last.
  - Neither high -> stay in IDLE.
  - Arbitration latency: s_cyc_o rises exactly 1 cycle after the first mX_cyc_i sample.
- OWNx, while mX_cyc_i is high:
  - Hold ownership. Bus is locked for the whole cyc, including multiple stb phases.
  - The other master's request is ignored.
- OWNx, when mX_cyc_i is sampled low:
  - Set last = x.
  - If the other master's cyc is high, go directly to OWNy (handover, no idle cycle). Otherwise go to IDLE.
- Slave muxing (combinational from state):
  - s_cyc_o = mX_cyc_i & OWNx. s_stb_o = mX_stb_i & OWNx.
  - s_we_o, s_sel_o, s_adr_o, s_dat_o follow the owner. They are all-zero in IDLE.
- Return path (combinational):
  - mX_ack_o = s_ack_i & OWNx & mX_stb_i.
  - mX_dat_o = s_dat_i when OWNx, else 0.
  - The non-owner never sees ack.
- Slave acking while s_stb_o is low is illegal; the arbiter drops it (no master ack).

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- Enabled:
  - Counter increments each cycle s_stb_o=1 and s_ack_i=0. It clears on ack, on state change, or when stb is low.
  - When the count reaches TIMEOUT-1 with no ack, the owner gets mX_err_o = 1 for exactly one cycle.
  - On the following edge the arbiter forces state to IDLE, sets last = x, and drops s_cyc_o. This is regardless of mX_cyc_i.
  - The master then has to deassert cyc and re-request.
  - An ack in the same cycle as the count reaching TIMEOUT-1 wins: ack issued, no err.
- Disabled: m0_err_o and m1_err_o are constant 0, there is no counter, and a missing ack stalls the bus indefinitely.

Test Plan:
1. Reset, then m0 read32 0xaabbccdd with the slave acking data 0x33445566:
   - grant_o = 01 one cycle after m0_cyc_i.
   - s_adr_o = 0xaabbccdd.
   - m0_dat_o = 0x33445566 with m0_ack_o.
   - m1_ack_o stays 0.
2. m0 and m1 assert cyc on the same edge after reset:
   - m0 granted first.
   - On m0 release, direct handover to m1 with no IDLE cycle; m1 write 0xaaaa5555 <- 0x01010202 appears on s_adr_o/s_dat_o with s_we_o = 1.
3. Fairness: both masters request continuously, one word each:
   - Grants alternate 01,10,01,10 over 4 transfers.
4. Reset mid-transfer: wb_rst_i is asserted while OWN1 and stb are high.
   - Next cycle: s_cyc_o = 0, grant_o = 00, no ack.
   - After release, a tie grants m0.
5. Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT = 16): m0 strobes and the slave never acks.
   - m0_err_o pulses 1 cycle at the 16th stb cycle; next cycle s_cyc_o = 0.
   - Rebuilt without the macro: err stays 0 and the bus is still held after 30 cycles.
6. Slave ack arriving while IDLE or with stb low -> no mX_ack_o asserted.
